// File: rtl/icache_pkg.sv
// Shared definitions for the direct-mapped instruction cache: FSM encoding and
// helpers that derive the address field widths from the geometry parameters.
package icache_pkg;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_FILL = 1'b1
    } state_e;

    function automatic int clog2(input int n);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < n) begin
                r = i + 1;
            end
        end
        return r;
    endfunction

    function automatic int ofs_w(input int block_words);
        return clog2(block_words);
    endfunction

    function automatic int idx_w(input int depth);
        return clog2(depth);
    endfunction

    function automatic int tag_w(input int depth, input int block_words);
        return 30 - clog2(depth) - clog2(block_words);
    endfunction

endpackage

// File: rtl/icache_array.sv
// Tag, valid and data storage for the instruction cache. Reads are combinational;
// word, tag and clear updates take effect at the clock edge.
module icache_array
    import icache_pkg::*;
#(
    parameter int DEPTH       = 32,
    parameter int BLOCK_WORDS = 4,
    localparam int IDX        = idx_w(DEPTH),
    localparam int OFS        = ofs_w(BLOCK_WORDS),
    localparam int TAG        = tag_w(DEPTH, BLOCK_WORDS)
) (
    input  logic           i_clk,
    input  logic           i_clr,
    input  logic [IDX-1:0] i_rd_index,
    input  logic [OFS-1:0] i_rd_offset,
    output logic [31:0]    o_rd_data,
    output logic [TAG-1:0] o_rd_tag,
    output logic           o_rd_valid,
    input  logic           i_wr_en,
    input  logic [IDX-1:0] i_wr_index,
    input  logic [OFS-1:0] i_wr_offset,
    input  logic [31:0]    i_wr_data,
    input  logic           i_tag_we,
    input  logic [IDX-1:0] i_tag_index,
    input  logic [TAG-1:0] i_tag
);

    localparam int WORDS = DEPTH * BLOCK_WORDS;

    logic [DEPTH-1:0] valid_q;
    logic [DEPTH-1:0] valid_d;
    logic [TAG-1:0]   tag_q  [DEPTH];
    logic [TAG-1:0]   tag_d  [DEPTH];
    logic [31:0]      data_q [WORDS];
    logic [31:0]      data_d [WORDS];

    logic [IDX+OFS-1:0] rd_word;
    logic [IDX+OFS-1:0] wr_word;

    assign rd_word = {i_rd_index, i_rd_offset};
    assign wr_word = {i_wr_index, i_wr_offset};

    assign o_rd_data  = data_q[rd_word];
    assign o_rd_tag   = tag_q[i_rd_index];
    assign o_rd_valid = valid_q[i_rd_index];

    // Clear wins over a same-cycle tag write so a reset mid-refill leaves no valid line.
    always_comb begin
        valid_d = valid_q;
        tag_d   = tag_q;
        data_d  = data_q;
        if (i_wr_en) begin
            data_d[wr_word] = i_wr_data;
        end
        if (i_tag_we) begin
            tag_d[i_tag_index]   = i_tag;
            valid_d[i_tag_index] = 1'b1;
        end
        if (i_clr) begin
            valid_d = '0;
        end
    end

    always_ff @(posedge i_clk) begin
        valid_q <= valid_d;
        tag_q   <= tag_d;
        data_q  <= data_d;
    end

endmodule

// File: rtl/icache.sv
// Direct-mapped, read-only instruction cache with zero-latency hits and a
// one-word-outstanding line refill from main memory on a miss.
module icache
    import icache_pkg::*;
#(
    parameter int DEPTH       = 32,
    parameter int BLOCK_WORDS = 4
) (
    input  logic        i_clk,
    input  logic        i_rst_n,
    input  logic        i_req_ren,
    input  logic [31:0] i_req_addr,
    output logic [31:0] o_res_rdata,
    output logic        o_busy,
    output logic        o_mem_ren,
    output logic [31:0] o_mem_addr,
    input  logic        i_mem_ready,
    input  logic        i_mem_valid,
    input  logic [31:0] i_mem_rdata
);

    localparam int OFS = ofs_w(BLOCK_WORDS);
    localparam int IDX = idx_w(DEPTH);
    localparam int TAG = tag_w(DEPTH, BLOCK_WORDS);
    localparam int CW  = OFS + 1;

    localparam logic [CW-1:0] CNT_LAST = CW'(BLOCK_WORDS - 1);
    localparam logic [CW-1:0] CNT_END  = CW'(BLOCK_WORDS);

    state_e         state_q;
    state_e         state_d;
    logic [CW-1:0]  cnt_req_q;
    logic [CW-1:0]  cnt_req_d;
    logic [CW-1:0]  cnt_rsp_q;
    logic [CW-1:0]  cnt_rsp_d;
    logic           outst_q;
    logic           outst_d;
    logic [31:0]    miss_addr_q;
    logic [31:0]    miss_addr_d;

    logic [IDX-1:0] req_index;
    logic [OFS-1:0] req_offset;
    logic [TAG-1:0] req_tag;
    logic [IDX-1:0] miss_index;
    logic [TAG-1:0] miss_tag;

    logic [31:0]    rd_data;
    logic [TAG-1:0] rd_tag;
    logic           rd_valid;
    logic           hit;
    logic           mem_ren;
    logic           wr_en;
    logic           tag_we;
    logic           unused_addr_bits;

    assign req_offset = i_req_addr[OFS+1:2];
    assign req_index  = i_req_addr[IDX+OFS+1:OFS+2];
    assign req_tag    = i_req_addr[31:IDX+OFS+2];
    assign miss_index = miss_addr_q[IDX+OFS+1:OFS+2];
    assign miss_tag   = miss_addr_q[31:IDX+OFS+2];

    assign unused_addr_bits = ^i_req_addr[1:0];

    icache_array #(
        .DEPTH       (DEPTH),
        .BLOCK_WORDS (BLOCK_WORDS)
    ) u_array (
        .i_clk       (i_clk),
        .i_clr       (!i_rst_n),
        .i_rd_index  (req_index),
        .i_rd_offset (req_offset),
        .o_rd_data   (rd_data),
        .o_rd_tag    (rd_tag),
        .o_rd_valid  (rd_valid),
        .i_wr_en     (wr_en),
        .i_wr_index  (miss_index),
        .i_wr_offset (cnt_rsp_q[OFS-1:0]),
        .i_wr_data   (i_mem_rdata),
        .i_tag_we    (tag_we),
        .i_tag_index (miss_index),
        .i_tag       (miss_tag)
    );

    assign hit         = i_req_ren & rd_valid & (rd_tag == req_tag);
    assign o_busy      = i_req_ren & ((state_q != ST_IDLE) | !hit);
    assign o_res_rdata = rd_data;
    assign o_mem_ren   = mem_ren;
    assign o_mem_addr  = (state_q == ST_FILL)
                       ? miss_addr_q + {{(30-CW){1'b0}}, cnt_req_q, 2'b00}
                       : 32'h0;

    // A request is only issued with nothing outstanding, so acceptance and a
    // returning word can never both be live in the same FILL cycle.
    always_comb begin
        state_d     = state_q;
        cnt_req_d   = cnt_req_q;
        cnt_rsp_d   = cnt_rsp_q;
        outst_d     = outst_q;
        miss_addr_d = miss_addr_q;
        mem_ren     = 1'b0;
        wr_en       = 1'b0;
        tag_we      = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (i_req_ren && !hit) begin
                    miss_addr_d = {i_req_addr[31:OFS+2], {(OFS+2){1'b0}}};
                    cnt_req_d   = '0;
                    cnt_rsp_d   = '0;
                    outst_d     = 1'b0;
                    state_d     = ST_FILL;
                end
            end
            ST_FILL: begin
                mem_ren = !outst_q && (cnt_req_q != CNT_END);
                if (mem_ren && i_mem_ready) begin
                    cnt_req_d = cnt_req_q + CW'(1);
                    outst_d   = 1'b1;
                end else if (outst_q && i_mem_valid) begin
                    wr_en     = 1'b1;
                    cnt_rsp_d = cnt_rsp_q + CW'(1);
                    outst_d   = 1'b0;
                    if (cnt_rsp_q == CNT_LAST) begin
                        tag_we  = 1'b1;
                        state_d = ST_IDLE;
                    end
                end
            end
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            state_q   <= ST_IDLE;
            cnt_req_q <= '0;
            cnt_rsp_q <= '0;
            outst_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_req_q <= cnt_req_d;
            cnt_rsp_q <= cnt_rsp_d;
            outst_q   <= outst_d;
        end
        miss_addr_q <= miss_addr_d;
    end

endmodule
